// File: rtl/lockout_ctrl.sv
// lockout_ctrl: access-attempt sequencer with failure counting and a timed
// lockout. After MAX_FAILS consecutive failed entries the block locks and
// counts down a 2-digit BCD seconds value from LOCK_TENS:LOCK_ONES. An
// internal prescaler produces one tick every TICK_DIV clock cycles. While
// locked, every attempt is rejected.
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous active-high reset
//   attempt_valid one-cycle strobe, code entry complete
//   attempt_ok    qualifies attempt_valid (1 = code matched)
//   admin_clr     synchronous override: abort lockout, clear fail count
//   grant         registered one-cycle pulse, access granted
//   reject        registered one-cycle pulse, attempt failed or refused
//   locked        high throughout lockout
//   fail_cnt      current consecutive failure count
//   secs_tens     BCD tens of remaining lockout seconds
//   secs_ones     BCD ones of remaining lockout seconds
module lockout_ctrl #(
  parameter int unsigned MAX_FAILS = 3,
  parameter int unsigned LOCK_TENS = 3,
  parameter int unsigned LOCK_ONES = 0,
  parameter int unsigned TICK_DIV  = 100000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       attempt_valid,
  input  logic       attempt_ok,
  input  logic       admin_clr,
  output logic       grant,
  output logic       reject,
  output logic       locked,
  output logic [3:0] fail_cnt,
  output logic [3:0] secs_tens,
  output logic [3:0] secs_ones
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [3:0] FAIL_LAST = 4'(MAX_FAILS - 1);
  localparam logic [3:0] INIT_TENS = 4'(LOCK_TENS);
  localparam logic [3:0] INIT_ONES = 4'(LOCK_ONES);

  typedef enum logic {
    ARMED,
    LOCKOUT
  } state_t;

  state_t        state;
  logic [PW-1:0] prescaler;

  // Single-process FSM: attempt handling, prescaler and BCD countdown.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ARMED;
      grant     <= 1'b0;
      reject    <= 1'b0;
      locked    <= 1'b0;
      fail_cnt  <= 4'd0;
      secs_tens <= 4'd0;
      secs_ones <= 4'd0;
      prescaler <= '0;
    end else begin
      grant  <= 1'b0;
      reject <= 1'b0;
      if (admin_clr) begin
        // Override wins over any coincident attempt; the attempt is dropped.
        state     <= ARMED;
        locked    <= 1'b0;
        fail_cnt  <= 4'd0;
        secs_tens <= 4'd0;
        secs_ones <= 4'd0;
        prescaler <= '0;
      end else begin
        case (state)
          ARMED: begin
            prescaler <= '0;
            if (attempt_valid) begin
              if (attempt_ok) begin
                grant    <= 1'b1;
                fail_cnt <= 4'd0;
              end else begin
                reject <= 1'b1;
                if (fail_cnt == FAIL_LAST) begin
                  state     <= LOCKOUT;
                  locked    <= 1'b1;
                  fail_cnt  <= 4'd0;
                  secs_tens <= INIT_TENS;
                  secs_ones <= INIT_ONES;
                end else begin
                  fail_cnt <= fail_cnt + 4'd1;
                end
              end
            end
          end

          LOCKOUT: begin
            if (attempt_valid) begin
              reject <= 1'b1;
            end
            if (prescaler == TICK_LAST) begin
              prescaler <= '0;
              // Reaching 01 on a tick ends the lockout; digits land on 00.
              if (secs_tens == 4'd0 && secs_ones == 4'd1) begin
                state     <= ARMED;
                locked    <= 1'b0;
                secs_ones <= 4'd0;
              end else if (secs_ones != 4'd0) begin
                secs_ones <= secs_ones - 4'd1;
              end else begin
                secs_ones <= 4'd9;
                secs_tens <= secs_tens - 4'd1;
              end
            end else begin
              prescaler <= prescaler + PW'(1);
            end
          end

          default: begin
            state  <= ARMED;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lockout_ctrl.sv
// Directed testbench for lockout_ctrl (TICK_DIV=4, MAX_FAILS=3, lock 12 s).
module tb_lockout_ctrl;

  logic       clk;
  logic       reset;
  logic       attempt_valid;
  logic       attempt_ok;
  logic       admin_clr;
  logic       grant;
  logic       reject;
  logic       locked;
  logic [3:0] fail_cnt;
  logic [3:0] secs_tens;
  logic [3:0] secs_ones;

  int tests;
  int fails;

  lockout_ctrl #(
    .MAX_FAILS(3),
    .LOCK_TENS(1),
    .LOCK_ONES(2),
    .TICK_DIV (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .attempt_valid(attempt_valid),
    .attempt_ok   (attempt_ok),
    .admin_clr    (admin_clr),
    .grant        (grant),
    .reject       (reject),
    .locked       (locked),
    .fail_cnt     (fail_cnt),
    .secs_tens    (secs_tens),
    .secs_ones    (secs_ones)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    attempt_valid = 1'b0;
    attempt_ok    = 1'b0;
    admin_clr     = 1'b0;
  endtask

  // Three back-to-back fails from a zero fail count; ends on the entry edge.
  task automatic enter_lockout(input string tag);
    for (int i = 0; i < 3; i++) begin
      attempt_valid = 1'b1;
      attempt_ok    = 1'b0;
      step();
    end
    idle_inputs();
    tests++;
    if ({grant, reject, locked, fail_cnt, secs_tens, secs_ones} !== {1'b0, 1'b1, 1'b1, 4'd0, 4'd1, 4'd2}) begin
      fails++;
      $display("FAIL %s_entry: g/r/l/fc/t/o got %b %b %b %0d %0d %0d want 0 1 1 0 1 2",
               tag, grant, reject, locked, fail_cnt, secs_tens, secs_ones);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({grant, reject, locked, fail_cnt, secs_tens, secs_ones} !== 15'd0) begin
      fails++;
      $display("FAIL reset_values: got %b %b %b %0d %0d %0d want all zero",
               grant, reject, locked, fail_cnt, secs_tens, secs_ones);
    end
    reset = 1'b0;
  endtask

  task automatic test_grant();
    attempt_valid = 1'b1;
    attempt_ok    = 1'b1;
    step();
    idle_inputs();
    tests++;
    if ({grant, reject, locked, fail_cnt} !== {1'b1, 1'b0, 1'b0, 4'd0}) begin
      fails++;
      $display("FAIL grant_pulse: g/r/l/fc got %b %b %b %0d want 1 0 0 0", grant, reject, locked, fail_cnt);
    end
    step();
    tests++;
    if ({grant, reject} !== 2'b00) begin
      fails++;
      $display("FAIL grant_one_cycle: g/r got %b %b want 0 0", grant, reject);
    end
  endtask

  task automatic test_fail_fail_ok();
    logic [3:0] exp_fc;
    for (int i = 1; i <= 2; i++) begin
      attempt_valid = 1'b1;
      attempt_ok    = 1'b0;
      step();
      idle_inputs();
      exp_fc = 4'(i);
      tests++;
      if ({grant, reject, locked, fail_cnt} !== {1'b0, 1'b1, 1'b0, exp_fc}) begin
        fails++;
        $display("FAIL fail_count_%0d: g/r/l/fc got %b %b %b %0d want 0 1 0 %0d",
                 i, grant, reject, locked, fail_cnt, exp_fc);
      end
      step();
    end
    attempt_valid = 1'b1;
    attempt_ok    = 1'b1;
    step();
    idle_inputs();
    tests++;
    if ({grant, reject, locked, fail_cnt} !== {1'b1, 1'b0, 1'b0, 4'd0}) begin
      fails++;
      $display("FAIL ok_clears_count: g/r/l/fc got %b %b %b %0d want 1 0 0 0", grant, reject, locked, fail_cnt);
    end
    step();
  endtask

  // Full countdown, with attempts injected; k counts edges after entry.
  task automatic test_countdown_with_attempts();
    int         rem;
    logic       exp_rej;
    logic       exp_lock;
    logic [3:0] exp_t;
    logic [3:0] exp_o;
    enter_lockout("cd");
    for (int k = 1; k <= 48; k++) begin
      // k=4 and k=8 coincide with ticks; k=3 and k=4 are valid+ok.
      exp_rej       = (k == 3 || k == 4 || k == 8 || k == 13);
      attempt_valid = exp_rej;
      attempt_ok    = (k != 13);
      step();
      idle_inputs();
      rem      = 12 - k / 4;
      exp_t    = 4'(rem / 10);
      exp_o    = 4'(rem % 10);
      exp_lock = (rem != 0);
      tests++;
      if ({grant, reject, locked, fail_cnt, secs_tens, secs_ones} !==
          {1'b0, exp_rej, exp_lock, 4'd0, exp_t, exp_o}) begin
        fails++;
        $display("FAIL countdown_k%0d: g/r/l/fc/t/o got %b %b %b %0d %0d %0d want 0 %b %b 0 %0d %0d",
                 k, grant, reject, locked, fail_cnt, secs_tens, secs_ones, exp_rej, exp_lock, exp_t, exp_o);
      end
    end
    step();
    tests++;
    if ({locked, secs_tens, secs_ones} !== 9'd0) begin
      fails++;
      $display("FAIL countdown_stays_00: l/t/o got %b %0d %0d want 0 0 0", locked, secs_tens, secs_ones);
    end
  endtask

  task automatic test_admin_clr();
    enter_lockout("adm");
    repeat (20) step();
    tests++;
    if ({locked, secs_tens, secs_ones} !== {1'b1, 4'd0, 4'd7}) begin
      fails++;
      $display("FAIL admin_pre_digits: l/t/o got %b %0d %0d want 1 0 7", locked, secs_tens, secs_ones);
    end
    admin_clr     = 1'b1;
    attempt_valid = 1'b1;
    attempt_ok    = 1'b1;
    step();
    idle_inputs();
    tests++;
    if ({grant, reject, locked, fail_cnt, secs_tens, secs_ones} !== 15'd0) begin
      fails++;
      $display("FAIL admin_clear: g/r/l/fc/t/o got %b %b %b %0d %0d %0d want all zero",
               grant, reject, locked, fail_cnt, secs_tens, secs_ones);
    end
    repeat (5) step();
    tests++;
    if ({grant, reject, locked, secs_tens, secs_ones} !== 11'd0) begin
      fails++;
      $display("FAIL admin_stays_armed: g/r/l/t/o got %b %b %b %0d %0d want all zero",
               grant, reject, locked, secs_tens, secs_ones);
    end
  endtask

  task automatic test_async_reset();
    enter_lockout("rst");
    repeat (6) step();
    #2;
    reset = 1'b1;
    #1;
    tests++;
    if ({grant, reject, locked, fail_cnt, secs_tens, secs_ones} !== 15'd0) begin
      fails++;
      $display("FAIL async_reset: g/r/l/fc/t/o got %b %b %b %0d %0d %0d want all zero",
               grant, reject, locked, fail_cnt, secs_tens, secs_ones);
    end
    #1;
    reset = 1'b0;
    step();
    repeat (4) step();
    tests++;
    if ({locked, secs_tens, secs_ones} !== 9'd0) begin
      fails++;
      $display("FAIL no_residual_tick: l/t/o got %b %0d %0d want 0 0 0", locked, secs_tens, secs_ones);
    end
    attempt_valid = 1'b1;
    attempt_ok    = 1'b0;
    step();
    idle_inputs();
    tests++;
    if ({grant, reject, locked, fail_cnt} !== {1'b0, 1'b1, 1'b0, 4'd1}) begin
      fails++;
      $display("FAIL post_reset_fail: g/r/l/fc got %b %b %b %0d want 0 1 0 1", grant, reject, locked, fail_cnt);
    end
  endtask

  task automatic test_ok_ignored_without_valid();
    attempt_valid = 1'b0;
    attempt_ok    = 1'b1;
    step();
    idle_inputs();
    tests++;
    if ({grant, reject, fail_cnt} !== {1'b0, 1'b0, 4'd1}) begin
      fails++;
      $display("FAIL ok_without_valid: g/r/fc got %b %b %0d want 0 0 1", grant, reject, fail_cnt);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_grant();
    test_fail_fail_ok();
    test_countdown_with_attempts();
    test_admin_clr();
    test_async_reset();
    test_ok_ignored_without_valid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lockout_ctrl.md
Name: lockout_ctrl

Overview:
Access-attempt sequencer for the security device. It counts consecutive failed code entries. After MAX_FAILS failures it enters a lockout and runs a 2-digit BCD countdown of remaining seconds, driven by an internal 1 Hz prescaler. While locked, every attempt is rejected; the BCD digits feed the seven-segment display path directly.

Parameters:
MAX_FAILS, 3, consecutive failures that trigger lockout (1..15)
LOCK_TENS, 3, tens digit of lockout duration in seconds (BCD 0..9)
LOCK_ONES, 0, ones digit of lockout duration in seconds (BCD 0..9); LOCK_TENS:LOCK_ONES must be >= 01
TICK_DIV, 100000000, clk cycles per countdown second (>= 2)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high; forces reset state immediately
attempt_valid  input  1  one-cycle strobe: a code entry is complete
attempt_ok  input  1  qualifies attempt_valid: 1 = code matched
admin_clr  input  1  synchronous override: abort lockout, clear fail count
grant  output  1  one-cycle pulse: access granted
reject  output  1  one-cycle pulse: attempt failed or refused
locked  output  1  high throughout lockout
fail_cnt  output  4  current consecutive failure count
secs_tens  output  4  BCD tens of remaining lockout seconds
secs_ones  output  4  BCD ones of remaining lockout seconds

Behaviour:
- Reset values (async): state ARMED, locked=0, grant=0, reject=0, fail_cnt=0, secs_tens=0, secs_ones=0, prescaler=0.
- grant and reject are registered outputs. Each goes high on the edge after the qualifying attempt_valid cycle, and stays high for exactly one cycle.
- States:
  - ARMED: locked=0; digits hold 00; prescaler held at 0.
  - LOCKOUT: locked=1.
- ARMED, attempt_valid & attempt_ok: grant=1, fail_cnt<=0.
- ARMED, attempt_valid & !attempt_ok: reject=1, fail_cnt<=fail_cnt+1.
  - If fail_cnt+1 == MAX_FAILS: go to LOCKOUT on the same edge.
  - On that edge: fail_cnt<=0, secs_tens<=LOCK_TENS, secs_ones<=LOCK_ONES, prescaler<=0.
- LOCKOUT, prescaler:
  - Counts 0..TICK_DIV-1, then wraps to 0.
  - The wrap cycle is a tick.
  - The first tick occurs TICK_DIV cycles after lockout entry.
- LOCKOUT, tick (BCD decrement):
  - If ones != 0: ones <= ones-1.
  - Else: ones <= 9, tens <= tens-1.
  - If the pre-decrement value is 01: digits become 00, state <= ARMED, locked <= 0, all on the same edge.
  - Total locked duration = (10*LOCK_TENS+LOCK_ONES)*TICK_DIV cycles exactly.
- LOCKOUT, attempt_valid (either ok value): reject=1, grant never asserted. fail_cnt stays 0; timer unaffected.
- Digits never wrap below 00. No value outside 0..9 is ever output on either digit.
- admin_clr (any state):
  - Next edge: state ARMED, fail_cnt=0, digits 00, prescaler 0, locked 0.
  - Priority over a coincident attempt_valid: the attempt is dropped, no grant or reject.
- Success in ARMED with fail_cnt>0 resets fail_cnt to 0; failures must be consecutive to trigger lockout.
- Tick and attempt_valid in the same LOCKOUT cycle: both are handled; reject pulses and the countdown decrements.
- Reset mid-lockout: immediate return to reset values; no residual tick.
- attempt_ok is ignored when attempt_valid=0.

Test Plan:
All scenarios use TICK_DIV=4, MAX_FAILS=3, LOCK_TENS=1, LOCK_ONES=2.

- Reset release, one valid+ok attempt -> grant pulses 1 cycle, reject=0, fail_cnt=0, locked=0.
- Fail, fail, ok -> fail_cnt 1 then 2, then grant pulses and fail_cnt=0; locked never rises.
- Three consecutive fails -> third reject pulses and locked=1 on the same edge. Digits read 1,2; fail_cnt=0.
  - Digits step 12, 11, 10, 09 (borrow on 10->09), …, 01, 00 at 4-cycle intervals.
  - locked falls on the 00 edge, exactly 48 cycles after entry.
- Attempts during lockout, including valid+ok and one coincident with a tick -> reject pulse each time, grant never asserted, countdown unaffected.
- admin_clr asserted with digits at 07, plus a coincident valid+ok -> next edge: locked=0, digits 00, fail_cnt=0, no grant or reject.
- Async reset pulse mid-lockout between clock edges -> outputs reach reset values without a clock edge. A subsequent single fail gives fail_cnt=1 and no lockout.
